// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller downstream of the execute stage. ALU results are
// forwarded to write-back with one cycle of latency. Loads and stores are run
// against a data memory that uses a Stall/Done handshake. Execute is held off
// through stall_out while a memory access is outstanding.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   ex_*                       instruction presented by execute
//   stall_out                  execute must hold its outputs stable
//   mem_Addr/DataIn/Rd/Wr      registered request to data memory
//   mem_DataOut/Stall/Done     memory response
//   wb_valid/data/writeReg/regWrite  registered write-back result
//   err                        pulses with wb_valid on illegal/aborted access
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluOut,
    input  logic [DATA_W-1:0] ex_wrData,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              ex_regWrite,
    input  logic [2:0]        ex_writeReg,
    output logic              stall_out,
    output logic [DATA_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_DataIn,
    output logic              mem_Rd,
    output logic              mem_Wr,
    input  logic [DATA_W-1:0] mem_DataOut,
    input  logic              mem_Stall,
    input  logic              mem_Done,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_writeReg,
    output logic              wb_regWrite,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load_q, load_d;
    logic              regw_q, regw_d;
    logic [2:0]        wreg_q, wreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              wbv_q, wbv_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic [2:0]        wbreg_q, wbreg_d;
    logic              wbrw_q, wbrw_d;
    logic              complete, abort;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        load_d   = load_q;
        regw_d   = regw_q;
        wreg_d   = wreg_q;
        cnt_d    = cnt_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        wbv_d    = 1'b0;
        err_d    = 1'b0;
        wbdata_d = wbdata_q;
        wbreg_d  = wbreg_q;
        wbrw_d   = wbrw_q;
        complete = 1'b0;
        abort    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_memRead && !ex_memWrite) begin
                        wbv_d    = 1'b1;
                        wbdata_d = ex_aluOut;
                        wbreg_d  = ex_writeReg;
                        wbrw_d   = ex_regWrite;
                    end else if ((ex_memRead ^ ex_memWrite) && !ex_aluOut[0]) begin
                        addr_d  = ex_aluOut;
                        data_d  = ex_wrData;
                        load_d  = ex_memRead;
                        regw_d  = ex_regWrite;
                        wreg_d  = ex_writeReg;
                        rd_d    = ex_memRead;
                        wr_d    = ex_memWrite;
                        state_d = ISSUE;
                    end else begin
                        // misaligned or read+write: reported, never issued
                        wbv_d    = 1'b1;
                        err_d    = 1'b1;
                        wbdata_d = ex_aluOut;
                        wbreg_d  = ex_writeReg;
                        wbrw_d   = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (mem_Stall) begin
                    // not accepted: re-present the identical request
                    rd_d = load_q;
                    wr_d = ~load_q;
                end else if (mem_Done) begin
                    complete = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // Done wins over a timeout landing in the same cycle
                if (mem_Done) begin
                    complete = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == TO_V) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete || abort) begin
            wbv_d    = 1'b1;
            err_d    = abort;
            wbreg_d  = wreg_q;
            wbrw_d   = complete & load_q & regw_q;
            wbdata_d = (complete && load_q) ? mem_DataOut : addr_q;
            state_d  = IDLE;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            regw_q   <= 1'b0;
            wreg_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wbv_q    <= 1'b0;
            err_q    <= 1'b0;
            wbdata_q <= '0;
            wbreg_q  <= '0;
            wbrw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            load_q   <= load_d;
            regw_q   <= regw_d;
            wreg_q   <= wreg_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wbv_q    <= wbv_d;
            err_q    <= err_d;
            wbdata_q <= wbdata_d;
            wbreg_q  <= wbreg_d;
            wbrw_q   <= wbrw_d;
        end
    end

    assign stall_out   = (state_q != IDLE);
    assign mem_Addr    = addr_q;
    assign mem_DataIn  = data_q;
    assign mem_Rd      = rd_q;
    assign mem_Wr      = wr_q;
    assign wb_valid    = wbv_q;
    assign err         = err_q;
    assign wb_data     = wbdata_q;
    assign wb_writeReg = wbreg_q;
    assign wb_regWrite = wbrw_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of single-cycle ops, directed multi-cycle
// sequences, and randomized transactions against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_regWrite;
    logic [15:0] ex_aluOut, ex_wrData;
    logic [2:0]  ex_writeReg;
    logic        stall_out, mem_Rd, mem_Wr, mem_Stall, mem_Done;
    logic [15:0] mem_Addr, mem_DataIn, mem_DataOut;
    logic        wb_valid, wb_regWrite, err;
    logic [15:0] wb_data;
    logic [2:0]  wb_writeReg;

    int n_cmp = 0;
    int n_bad = 0;

    // device memory (written from DUT outputs) and reference memory (from ex_*)
    logic [15:0] dev_mem [128];
    logic [15:0] ref_mem [128];

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_wrData(ex_wrData),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
        .stall_out(stall_out), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
        .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_DataOut(mem_DataOut),
        .mem_Stall(mem_Stall), .mem_Done(mem_Done),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_writeReg(wb_writeReg),
        .wb_regWrite(wb_regWrite), .err(err)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One instruction from acceptance to write-back. s = stall cycles in ISSUE,
    // w = WAIT cycles until Done (0: Done in last ISSUE cycle), to = never Done.
    // nx: an ALU op presented during the stall, expected right after.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] d,
                           input logic rd, input logic wr, input logic rg,
                           input logic [2:0] wrg, input int s, input int w,
                           input bit to, input bit nx, input logic [15:0] nxa,
                           input logic [2:0] nxr);
        bit memop, legal, exp_err, dn;
        int L, j;
        logic exp_rw;
        memop   = rd | wr;
        legal   = (rd ^ wr) && !a[0];
        exp_err = memop && (!legal || to);
        L       = (!memop || !legal) ? 1 : s + 2 + (to ? TO + 1 : w);
        exp_rw  = !memop ? rg : (exp_err ? 1'b0 : (rd & rg));

        ex_valid = 1'b1; ex_aluOut = a; ex_wrData = d; ex_memRead = rd;
        ex_memWrite = wr; ex_regWrite = rg; ex_writeReg = wrg;
        mem_Stall = 1'($urandom); mem_Done = 1'($urandom);
        mem_DataOut = 16'($urandom);

        for (int k = 1; k <= L; k++) begin
            tick();
            if (k == L) begin
                chk1("wb_valid", wb_valid, 1'b1);
                chk1("err", err, exp_err);
                chk1("wb_regWrite", wb_regWrite, exp_rw);
                chk16("wb_writeReg", 16'(wb_writeReg), 16'(wrg));
                if (!exp_err && !wr)
                    chk16("wb_data", wb_data, rd ? ref_mem[a[7:1]] : a);
                chk1("stall_done", stall_out, 1'b0);
                chk1("rd_done", mem_Rd, 1'b0);
                chk1("wr_done", mem_Wr, 1'b0);
                if (memop && legal && wr && !to) ref_mem[a[7:1]] = d;
            end else begin
                chk1("stall_busy", stall_out, 1'b1);
                chk1("wbv_busy", wb_valid, 1'b0);
                chk1("mem_Rd", mem_Rd, (k <= s + 1) & rd);
                chk1("mem_Wr", mem_Wr, (k <= s + 1) & wr);
                chk16("mem_Addr", mem_Addr, a);
                chk16("mem_DataIn", mem_DataIn, d);
            end

            if (nx) begin
                ex_valid = 1'b1; ex_aluOut = nxa; ex_memRead = 1'b0;
                ex_memWrite = 1'b0; ex_regWrite = 1'b1; ex_writeReg = nxr;
            end else begin
                ex_valid = 1'b0; ex_aluOut = 16'($urandom); ex_wrData = 16'($urandom);
                ex_memRead = 1'($urandom); ex_memWrite = 1'($urandom);
            end

            mem_DataOut = 16'($urandom);
            if (k < L && memop && legal) begin
                if (k <= s) begin
                    mem_Stall = 1'b1; dn = 1'b0; mem_Done = 1'($urandom);
                end else if (k == s + 1) begin
                    mem_Stall = 1'b0; dn = !to && (w == 0); mem_Done = dn;
                end else begin
                    j = k - s - 1;
                    mem_Stall = 1'($urandom); dn = !to && (j == w); mem_Done = dn;
                end
                if (dn && rd) mem_DataOut = dev_mem[mem_Addr[7:1]];
                if (dn && wr) dev_mem[mem_Addr[7:1]] = mem_DataIn;
            end else begin
                mem_Stall = 1'($urandom); mem_Done = 1'($urandom);
            end
        end

        tick();
        if (nx) begin
            chk1("nx_wbv", wb_valid, 1'b1);
            chk1("nx_err", err, 1'b0);
            chk16("nx_data", wb_data, nxa);
            chk16("nx_reg", 16'(wb_writeReg), 16'(nxr));
            chk1("nx_rw", wb_regWrite, 1'b1);
            ex_valid = 1'b0;
            tick();
        end
        chk1("wbv_pulse", wb_valid, 1'b0);
        chk1("err_pulse", err, 1'b0);
        chk1("stall_idle", stall_out, 1'b0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rd, wr, rg;
        logic [2:0]  wrg;
        logic        e_err, e_rw;
        logic [15:0] e_data;
    } vec_t;

    vec_t vt [8];

    initial begin
        // table of single-cycle ops, applied back to back
        vt[0] = '{16'h1234, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 16'h1234};
        vt[1] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 16'hFFFF};
        vt[2] = '{16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0000};
        vt[3] = '{16'h0021, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 16'h0000};
        vt[4] = '{16'h0040, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 16'h0000};
        vt[5] = '{16'h0033, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 16'h0000};
        vt[6] = '{16'hABCD, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 16'hABCD};
        vt[7] = '{16'h8001, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 16'h8001};

        for (int i = 0; i < 128; i++) begin
            dev_mem[i] = 16'($urandom);
            ref_mem[i] = dev_mem[i];
        end

        rst = 1'b1; ex_valid = 1'b0; ex_aluOut = '0; ex_wrData = '0;
        ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_regWrite = 1'b0; ex_writeReg = '0;
        mem_Stall = 1'b0; mem_Done = 1'b0; mem_DataOut = '0;
        repeat (3) tick();
        chk1("rst_stall", stall_out, 1'b0);
        chk1("rst_rd", mem_Rd, 1'b0);
        chk1("rst_wr", mem_Wr, 1'b0);
        chk16("rst_addr", mem_Addr, 16'h0);
        chk16("rst_din", mem_DataIn, 16'h0);
        chk1("rst_wbv", wb_valid, 1'b0);
        chk16("rst_wbdata", wb_data, 16'h0);
        chk16("rst_wbreg", 16'(wb_writeReg), 16'h0);
        chk1("rst_rw", wb_regWrite, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            ex_valid = 1'b1; ex_aluOut = vt[i].a; ex_wrData = 16'($urandom);
            ex_memRead = vt[i].rd; ex_memWrite = vt[i].wr;
            ex_regWrite = vt[i].rg; ex_writeReg = vt[i].wrg;
            mem_Done = 1'($urandom);
            tick();
            chk1("tbl_wbv", wb_valid, 1'b1);
            chk1("tbl_err", err, vt[i].e_err);
            chk1("tbl_rw", wb_regWrite, vt[i].e_rw);
            chk16("tbl_reg", 16'(wb_writeReg), 16'(vt[i].wrg));
            if (!vt[i].e_err) chk16("tbl_data", wb_data, vt[i].e_data);
            chk1("tbl_stall", stall_out, 1'b0);
            chk1("tbl_rd", mem_Rd, 1'b0);
            chk1("tbl_wr", mem_Wr, 1'b0);
        end
        ex_valid = 1'b0; mem_Done = 1'b0;
        tick();
        chk1("tbl_end_wbv", wb_valid, 1'b0);

        // load, Done during ISSUE
        dev_mem[16'h0040 >> 1] = 16'hBEEF; ref_mem[16'h0040 >> 1] = 16'hBEEF;
        run_txn(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 0, 0, 1'b0, 1'b0, 16'h0, 3'd0);
        // store stalled 3 cycles, Done two WAIT cycles later; read it back
        run_txn(16'h0010, 16'h00AA, 1'b0, 1'b1, 1'b1, 3'd2, 3, 2, 1'b0, 1'b0, 16'h0, 3'd0);
        run_txn(16'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 0, 1, 1'b0, 1'b0, 16'h0, 3'd0);
        // misaligned load
        run_txn(16'h0021, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 0, 0, 1'b0, 1'b0, 16'h0, 3'd0);
        // timeout, then a normal ALU op
        run_txn(16'h0062, 16'h0, 1'b1, 1'b0, 1'b1, 3'd3, 1, 0, 1'b1, 1'b0, 16'h0, 3'd0);
        run_txn(16'h7777, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6, 0, 0, 1'b0, 1'b0, 16'h0, 3'd0);
        // ALU op presented during a load is taken in the first IDLE cycle
        run_txn(16'h0024, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1, 2, 1'b0, 1'b1, 16'h5A5A, 3'd6);

        // reset while in WAIT abandons the access
        ex_valid = 1'b1; ex_aluOut = 16'h0060; ex_memRead = 1'b1; ex_memWrite = 1'b0;
        ex_regWrite = 1'b1; ex_writeReg = 3'd2; mem_Stall = 1'b0; mem_Done = 1'b0;
        tick();
        ex_valid = 1'b0;
        chk1("r6_issue_rd", mem_Rd, 1'b1);
        tick();
        chk1("r6_wait_rd", mem_Rd, 1'b0);
        chk1("r6_wait_stall", stall_out, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("r6_rd", mem_Rd, 1'b0);
        chk1("r6_wr", mem_Wr, 1'b0);
        chk1("r6_stall", stall_out, 1'b0);
        chk1("r6_wbv", wb_valid, 1'b0);
        chk16("r6_wbdata", wb_data, 16'h0);
        mem_Done = 1'b1; mem_DataOut = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("r6_late_wbv", wb_valid, 1'b0);
            chk1("r6_late_stall", stall_out, 1'b0);
            chk1("r6_late_rd", mem_Rd, 1'b0);
        end
        mem_Done = 1'b0;
        tick();

        // randomized transactions
        for (int t = 0; t < 150; t++) begin
            logic [15:0] a, d;
            logic rd, wr, rg;
            logic [2:0] wrg;
            int kind;
            kind = int'($urandom_range(0, 9));
            a = 16'($urandom); d = 16'($urandom);
            rg = 1'($urandom); wrg = 3'($urandom);
            if (kind < 3) begin
                rd = 1'b0; wr = 1'b0;
            end else if (kind == 3) begin
                if ($urandom_range(0, 1) == 0) begin
                    rd = 1'b1; wr = 1'b1;
                end else begin
                    rd = 1'($urandom); wr = !rd; a[0] = 1'b1;
                end
            end else begin
                rd = 1'($urandom); wr = !rd; a[0] = 1'b0;
            end
            run_txn(a, d, rd, wr, rg, wrg, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), $urandom_range(0, 11) == 0,
                    1'b0, 16'h0, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
